// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write integer register file with hardwired-zero x0,
// write-to-read bypass, per-register busy scoreboard and a multi-cycle
// sweep clear. Sits between decode and writeback.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     soft_clr,
    output logic                     clearing,
    input  logic [$clog2(NREGS)-1:0] addr1,
    input  logic [$clog2(NREGS)-1:0] addr2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    output logic                     rd1_busy,
    output logic                     rd2_busy,
    input  logic                     write_enable,
    input  logic [$clog2(NREGS)-1:0] addr3,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [AW-1:0]     ptr_r;
    logic              clearing_r;
    logic [XLEN-1:0]   mem_r [NREGS];
    logic [NREGS-1:0]  sb_r;
    logic [NREGS-1:0]  sb_s;
    logic              wr_ok_s;
    logic              byp1_s;
    logic              byp2_s;

    // Register 0 is the architectural zero only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Next-state logic: sweep starts on soft_clr, ends after the last index is cleared.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (soft_clr) state_s = ST_CLEAR;
                else          state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (ptr_r == LAST_IDX) state_s = ST_IDLE;
                else                   state_s = ST_CLEAR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, sweep pointer and registered clearing flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            clearing_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clearing_r <= (state_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                if (ptr_r == LAST_IDX) ptr_r <= '0;
                else                   ptr_r <= ptr_r + AW'(1);
            end else begin
                ptr_r <= '0;
            end
        end
    end

    // A write lands only in IDLE when no sweep is being requested this cycle.
    always_comb begin
        wr_ok_s = 1'b0;
        if ((state_r == ST_IDLE) && !soft_clr && write_enable && !is_zero_reg(addr3)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Register array: async reset, sweep clear one entry per cycle, else writeback.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) mem_r[i] <= '0;
        end else if (state_r == ST_CLEAR) begin
            mem_r[ptr_r] <= '0;
        end else if (wr_ok_s) begin
            mem_r[addr3] <= write_data;
        end
    end

    // Scoreboard update: clear on writeback first, then set on issue so a newer producer wins.
    always_comb begin
        sb_s = sb_r;
        if (state_r == ST_CLEAR) begin
            sb_s = '0;
        end else if (soft_clr) begin
            sb_s = '0;
        end else begin
            if (write_enable) sb_s[addr3] = 1'b0;
            if (issue_valid && !is_zero_reg(issue_rd)) sb_s[issue_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) sb_r <= '0;
        else        sb_r <= sb_s;
    end

    // Bypass hits: writeback data in flight to the register being read.
    always_comb begin
        byp1_s = (BYPASS != 0) && write_enable && (addr3 == addr1) && (state_r == ST_IDLE);
        byp2_s = (BYPASS != 0) && write_enable && (addr3 == addr2) && (state_r == ST_IDLE);
    end

    // Read port 1 data and busy.
    always_comb begin
        rd1      = '0;
        rd1_busy = 1'b0;
        if (is_zero_reg(addr1) || (state_r == ST_CLEAR)) begin
            rd1      = '0;
            rd1_busy = 1'b0;
        end else if (byp1_s) begin
            rd1      = write_data;
            rd1_busy = 1'b0;
        end else begin
            rd1      = mem_r[addr1];
            rd1_busy = sb_r[addr1];
        end
    end

    // Read port 2 data and busy.
    always_comb begin
        rd2      = '0;
        rd2_busy = 1'b0;
        if (is_zero_reg(addr2) || (state_r == ST_CLEAR)) begin
            rd2      = '0;
            rd2_busy = 1'b0;
        end else if (byp2_s) begin
            rd2      = write_data;
            rd2_busy = 1'b0;
        end else begin
            rd2      = mem_r[addr2];
            rd2_busy = sb_r[addr2];
        end
    end

    assign clearing = clearing_r;

endmodule
